// File: rtl/divider_arbiter.sv
// divider_arbiter: round-robin sharing of one sequential divider among
// NUM_REQ requesters. Divide-by-zero requests are answered locally.
// Optional feature macro: DIV_ARB_TIMEOUT_EN adds a WAIT-state watchdog that
// answers with an error response after TIMEOUT_CYCLES cycles without a result.
module divider_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int WIDTH          = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic [NUM_REQ-1:0]       req_valid_in,
    input  logic [NUM_REQ*WIDTH-1:0] req_dividend_in,
    input  logic [NUM_REQ*WIDTH-1:0] req_divisor_in,
    output logic [NUM_REQ-1:0]       req_ready_out,
    output logic [NUM_REQ-1:0]       resp_valid_out,
    output logic [WIDTH-1:0]         resp_quotient_out,
    output logic [WIDTH-1:0]         resp_remainder_out,
    output logic                     resp_error_out,
    output logic [WIDTH-1:0]         div_dividend_out,
    output logic [WIDTH-1:0]         div_divisor_out,
    output logic                     div_start_out,
    input  logic [WIDTH-1:0]         div_quotient_in,
    input  logic [WIDTH-1:0]         div_remainder_in,
    input  logic                     div_valid_in,
    output logic                     busy_out
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ZERO = 2'd2
    } state_t;

    state_t           state_reg;
    logic [IDX_W-1:0] owner_reg;
    logic [IDX_W-1:0] rr_ptr_reg;
    logic [WIDTH-1:0] zero_dividend_reg;

    // Unpacked views of the packed operand buses.
    logic [WIDTH-1:0] dividend_arr [NUM_REQ];
    logic [WIDTH-1:0] divisor_arr  [NUM_REQ];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign dividend_arr[gi] = req_dividend_in[gi*WIDTH +: WIDTH];
            assign divisor_arr[gi]  = req_divisor_in[gi*WIDTH +: WIDTH];
        end
    endgenerate

`ifdef DIV_ARB_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMR_W-1:0] timer_reg;
`endif

    logic             grant_found;
    logic [IDX_W-1:0] grant_idx;
    logic [IDX_W-1:0] next_ptr;
    logic [IDX_W:0]   cand;

    // Winner = first set request bit scanning upward from rr_ptr with wrap.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, rr_ptr_reg} + (IDX_W+1)'(k);
            if (cand >= (IDX_W+1)'(NUM_REQ)) begin
                cand = cand - (IDX_W+1)'(NUM_REQ);
            end
            if (!grant_found && req_valid_in[cand[IDX_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[IDX_W-1:0];
            end
        end
        next_ptr = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end

    // Arbitration FSM; every output is registered here.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_reg          <= IDLE;
            owner_reg          <= '0;
            rr_ptr_reg         <= '0;
            zero_dividend_reg  <= '0;
            req_ready_out      <= '0;
            resp_valid_out     <= '0;
            resp_quotient_out  <= '0;
            resp_remainder_out <= '0;
            resp_error_out     <= 1'b0;
            div_dividend_out   <= '0;
            div_divisor_out    <= '0;
            div_start_out      <= 1'b0;
            busy_out           <= 1'b0;
`ifdef DIV_ARB_TIMEOUT_EN
            timer_reg          <= '0;
`endif
        end else begin
            // Pulses default low; data outputs hold their last value.
            req_ready_out  <= '0;
            resp_valid_out <= '0;
            div_start_out  <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (grant_found) begin
                        owner_reg         <= grant_idx;
                        rr_ptr_reg        <= next_ptr;
                        req_ready_out     <= NUM_REQ'(1) << grant_idx;
                        zero_dividend_reg <= dividend_arr[grant_idx];
                        busy_out          <= 1'b1;
                        if (divisor_arr[grant_idx] == '0) begin
                            // Divider is left untouched for a zero divisor.
                            state_reg <= ZERO;
                        end else begin
                            div_dividend_out <= dividend_arr[grant_idx];
                            div_divisor_out  <= divisor_arr[grant_idx];
                            div_start_out    <= 1'b1;
                            state_reg        <= WAIT;
`ifdef DIV_ARB_TIMEOUT_EN
                            timer_reg        <= '0;
`endif
                        end
                    end
                end
                WAIT: begin
                    if (div_valid_in) begin
                        // A real result always beats a simultaneous timeout.
                        resp_quotient_out  <= div_quotient_in;
                        resp_remainder_out <= div_remainder_in;
                        resp_error_out     <= 1'b0;
                        resp_valid_out     <= NUM_REQ'(1) << owner_reg;
                        busy_out           <= 1'b0;
                        state_reg          <= IDLE;
                    end
`ifdef DIV_ARB_TIMEOUT_EN
                    else if (timer_reg == TMR_W'(TIMEOUT_CYCLES - 1)) begin
                        resp_quotient_out  <= '0;
                        resp_remainder_out <= '0;
                        resp_error_out     <= 1'b1;
                        resp_valid_out     <= NUM_REQ'(1) << owner_reg;
                        busy_out           <= 1'b0;
                        state_reg          <= IDLE;
                    end else begin
                        timer_reg <= timer_reg + 1'b1;
                    end
`endif
                end
                ZERO: begin
                    resp_quotient_out  <= '1;
                    resp_remainder_out <= zero_dividend_reg;
                    resp_error_out     <= 1'b1;
                    resp_valid_out     <= NUM_REQ'(1) << owner_reg;
                    busy_out           <= 1'b0;
                    state_reg          <= IDLE;
                end
                default: begin
                    busy_out  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_divider_arbiter.sv
// Directed testbench for divider_arbiter; the bench plays the divider by hand.
module tb_divider_arbiter;

    localparam int N = 4;
    localparam int W = 32;

    logic           clk_in = 1'b0;
    logic           rst_in;
    logic [N-1:0]   req_valid_in;
    logic [N*W-1:0] req_dividend_in;
    logic [N*W-1:0] req_divisor_in;
    logic [N-1:0]   req_ready_out;
    logic [N-1:0]   resp_valid_out;
    logic [W-1:0]   resp_quotient_out;
    logic [W-1:0]   resp_remainder_out;
    logic           resp_error_out;
    logic [W-1:0]   div_dividend_out;
    logic [W-1:0]   div_divisor_out;
    logic           div_start_out;
    logic [W-1:0]   div_quotient_in;
    logic [W-1:0]   div_remainder_in;
    logic           div_valid_in;
    logic           busy_out;

    int total = 0;
    int bad   = 0;

    divider_arbiter #(.NUM_REQ(N), .WIDTH(W), .TIMEOUT_CYCLES(8)) dut (
        .clk_in             (clk_in),
        .rst_in             (rst_in),
        .req_valid_in       (req_valid_in),
        .req_dividend_in    (req_dividend_in),
        .req_divisor_in     (req_divisor_in),
        .req_ready_out      (req_ready_out),
        .resp_valid_out     (resp_valid_out),
        .resp_quotient_out  (resp_quotient_out),
        .resp_remainder_out (resp_remainder_out),
        .resp_error_out     (resp_error_out),
        .div_dividend_out   (div_dividend_out),
        .div_divisor_out    (div_divisor_out),
        .div_start_out      (div_start_out),
        .div_quotient_in    (div_quotient_in),
        .div_remainder_in   (div_remainder_in),
        .div_valid_in       (div_valid_in),
        .busy_out           (busy_out)
    );

    always #5 clk_in = ~clk_in;

    // Inputs change and outputs are checked on the falling edge.
    task automatic tick();
        @(negedge clk_in);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int idx, input logic [W-1:0] dvd, input logic [W-1:0] dvs);
        req_dividend_in[idx*W +: W] = dvd;
        req_divisor_in[idx*W +: W]  = dvs;
        req_valid_in[idx]           = 1'b1;
    endtask

    task automatic check_idle_zero(input string tag);
        chk({tag, "_ready"}, 64'(req_ready_out), 64'd0);
        chk({tag, "_resp_valid"}, 64'(resp_valid_out), 64'd0);
        chk({tag, "_quot"}, 64'(resp_quotient_out), 64'd0);
        chk({tag, "_rem"}, 64'(resp_remainder_out), 64'd0);
        chk({tag, "_err"}, 64'(resp_error_out), 64'd0);
        chk({tag, "_div_dvd"}, 64'(div_dividend_out), 64'd0);
        chk({tag, "_div_dvs"}, 64'(div_divisor_out), 64'd0);
        chk({tag, "_start"}, 64'(div_start_out), 64'd0);
        chk({tag, "_busy"}, 64'(busy_out), 64'd0);
    endtask

    // Grant expected at the next falling edge; divider answers after lat cycles.
    task automatic serve(input int idx, input logic [W-1:0] dvd, input logic [W-1:0] dvs,
                         input logic [W-1:0] q, input logic [W-1:0] r,
                         input bit rearm, input int lat);
        logic [N-1:0] oh;
        oh = N'(1) << idx;
        tick();
        chk("grant_ready", 64'(req_ready_out), 64'(oh));
        chk("grant_start", 64'(div_start_out), 64'd1);
        chk("grant_div_dvd", 64'(div_dividend_out), 64'(dvd));
        chk("grant_div_dvs", 64'(div_divisor_out), 64'(dvs));
        chk("grant_busy", 64'(busy_out), 64'd1);
        req_valid_in[idx] = 1'b0;
        for (int c = 0; c < lat; c++) begin
            tick();
            chk("wait_start_low", 64'(div_start_out), 64'd0);
            chk("wait_no_resp", 64'(resp_valid_out), 64'd0);
        end
        div_valid_in     = 1'b1;
        div_quotient_in  = q;
        div_remainder_in = r;
        tick();
        div_valid_in = 1'b0;
        chk("resp_valid", 64'(resp_valid_out), 64'(oh));
        chk("resp_quot", 64'(resp_quotient_out), 64'(q));
        chk("resp_rem", 64'(resp_remainder_out), 64'(r));
        chk("resp_err", 64'(resp_error_out), 64'd0);
        chk("resp_busy", 64'(busy_out), 64'd0);
        $display("txn: req=%0d %0d/%0d -> q=%0d r=%0d err=%0d", idx, dvd, dvs,
                 resp_quotient_out, resp_remainder_out, resp_error_out);
        if (rearm) req_valid_in[idx] = 1'b1;
    endtask

    initial begin
        rst_in           = 1'b1;
        req_valid_in     = '0;
        req_dividend_in  = '0;
        req_divisor_in   = '0;
        div_quotient_in  = '0;
        div_remainder_in = '0;
        div_valid_in     = 1'b0;

        // Reset state.
        tick();
        check_idle_zero("reset");
        tick();
        rst_in = 1'b0;

        // All four at once from reset: grants 0,1,2,3.
        set_req(0, 400, 4);
        set_req(1, 800, 4);
        set_req(2, 1200, 4);
        set_req(3, 1600, 4);
        serve(0, 400, 4, 100, 0, 1'b0, 2);
        serve(1, 800, 4, 200, 0, 1'b0, 1);
        serve(2, 1200, 4, 300, 0, 1'b0, 3);
        serve(3, 1600, 4, 400, 0, 1'b0, 1);
        chk("all4_valids_dropped", 64'(req_valid_in), 64'd0);

        // Single request on requester 2: 1000/7.
        tick();
        set_req(2, 1000, 7);
        serve(2, 1000, 7, 142, 6, 1'b0, 3);
        tick();
        chk("single_ready_clear", 64'(req_ready_out), 64'd0);

        // Fairness: 0 and 1 keep re-requesting; pointer is at 3 so 0 wins first.
        set_req(0, 90, 9);
        set_req(1, 77, 10);
        serve(0, 90, 9, 10, 0, 1'b1, 1);
        serve(1, 77, 10, 7, 7, 1'b1, 1);
        serve(0, 90, 9, 10, 0, 1'b0, 2);
        serve(1, 77, 10, 7, 7, 1'b0, 1);

        // Divide by zero on requester 3: 55/0.
        tick();
        set_req(3, 55, 0);
        tick();
        chk("zero_ready", 64'(req_ready_out), 64'b1000);
        chk("zero_start", 64'(div_start_out), 64'd0);
        chk("zero_busy", 64'(busy_out), 64'd1);
        chk("zero_no_resp_yet", 64'(resp_valid_out), 64'd0);
        req_valid_in[3] = 1'b0;
        tick();
        chk("zero_resp_valid", 64'(resp_valid_out), 64'b1000);
        chk("zero_quot", 64'(resp_quotient_out), 64'hFFFF_FFFF);
        chk("zero_rem", 64'(resp_remainder_out), 64'd55);
        chk("zero_err", 64'(resp_error_out), 64'd1);
        chk("zero_start2", 64'(div_start_out), 64'd0);
        chk("zero_div_dvd_hold", 64'(div_dividend_out), 64'd77);
        $display("txn: req=3 55/0 -> q=%0h r=%0d err=%0d",
                 resp_quotient_out, resp_remainder_out, resp_error_out);
        tick();
        chk("zero_pulse_end", 64'(resp_valid_out), 64'd0);

        // Asynchronous reset in the middle of WAIT.
        set_req(1, 500, 5);
        tick();
        chk("rst_grant", 64'(req_ready_out), 64'b0010);
        req_valid_in[1] = 1'b0;
        tick();
        chk("rst_busy_before", 64'(busy_out), 64'd1);
        #2 rst_in = 1'b1;
        #1 check_idle_zero("async_rst");
        tick();
        rst_in           = 1'b0;
        div_valid_in     = 1'b1;
        div_quotient_in  = 123;
        div_remainder_in = 4;
        tick();
        div_valid_in = 1'b0;
        chk("stale_no_resp", 64'(resp_valid_out), 64'd0);
        chk("stale_quot", 64'(resp_quotient_out), 64'd0);
        chk("stale_busy", 64'(busy_out), 64'd0);
        $display("txn: stale divider result after reset ignored");
        set_req(1, 500, 5);
        serve(1, 500, 5, 100, 0, 1'b0, 2);

`ifdef DIV_ARB_TIMEOUT_EN
        // Divider never answers: error response after the 8th WAIT cycle.
        tick();
        set_req(0, 30, 3);
        tick();
        chk("to_grant", 64'(req_ready_out), 64'b0001);
        req_valid_in[0] = 1'b0;
        for (int c = 2; c <= 8; c++) begin
            tick();
            chk("to_waiting", 64'(resp_valid_out), 64'd0);
        end
        tick();
        chk("to_resp_valid", 64'(resp_valid_out), 64'b0001);
        chk("to_quot", 64'(resp_quotient_out), 64'd0);
        chk("to_rem", 64'(resp_remainder_out), 64'd0);
        chk("to_err", 64'(resp_error_out), 64'd1);
        $display("txn: req=0 30/3 timeout -> err=%0d", resp_error_out);
        set_req(1, 60, 6);
        serve(1, 60, 6, 10, 0, 1'b0, 1);
`endif

        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
